// File: rtl/fifo_rd_stream_adapter_if.sv
// Signal bundle between the FIFO read port, the read-side adapter and the stream consumer.
// The adapter takes the master modport; the FIFO/consumer environment takes the slave modport.
interface fifo_rd_stream_adapter_if #(
  parameter int unsigned FIFO_WIDTH = 16,
  parameter int unsigned BUF_DEPTH  = 2,
  parameter int unsigned CNT_WIDTH  = 16
);

  logic                           fifo_empty;
  logic [FIFO_WIDTH-1:0]          fifo_data_out;
  logic                           fifo_rd_en;
  logic                           m_valid;
  logic                           m_ready;
  logic [FIFO_WIDTH-1:0]          m_data;
  logic [$clog2(BUF_DEPTH):0]     buf_count;
  logic [CNT_WIDTH-1:0]           xfer_count;

  modport master (
    input  fifo_empty,
    input  fifo_data_out,
    output fifo_rd_en,
    output m_valid,
    input  m_ready,
    output m_data,
    output buf_count,
    output xfer_count
  );

  modport slave (
    output fifo_empty,
    output fifo_data_out,
    input  fifo_rd_en,
    input  m_valid,
    output m_ready,
    input  m_data,
    input  buf_count,
    input  xfer_count
  );

endinterface

// File: rtl/fifo_rd_stream_adapter.sv
// Read-side FIFO stage: issues rd_en, captures the registered FIFO data one cycle later into
// a small skid buffer, and re-presents the words as a valid/ready stream.
module fifo_rd_stream_adapter #(
  parameter int unsigned FIFO_WIDTH = 16,
  parameter int unsigned BUF_DEPTH  = 2,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input logic                      clk,
  input logic                      rst_n,
  fifo_rd_stream_adapter_if.master bus
);

  localparam int unsigned PtrW = $clog2(BUF_DEPTH);
  localparam int unsigned OccW = PtrW + 1;
  localparam logic [OccW:0] DepthOcc = (OccW + 1)'(BUF_DEPTH);

  logic [FIFO_WIDTH-1:0] buf_mem_q [BUF_DEPTH];
  logic [FIFO_WIDTH-1:0] buf_mem_d [BUF_DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [OccW-1:0]       buf_count_q, buf_count_d;
  logic                  rd_pending_q, rd_pending_d;
  logic [CNT_WIDTH-1:0]  xfer_count_q, xfer_count_d;

  logic                  m_valid;
  logic                  pop;
  logic                  rd_en;
  logic [OccW:0]         occ_after;

  assign m_valid = (buf_count_q != '0);
  assign pop     = m_valid & bus.m_ready;

  // Occupancy once this cycle's pop and the in-flight capture have landed; one extra bit so
  // the comparison against BUF_DEPTH can never alias.
  always_comb begin
    occ_after = {1'b0, buf_count_q};
    if (rd_pending_q) begin
      occ_after = occ_after + 1'b1;
    end
    if (pop) begin
      occ_after = occ_after - 1'b1;
    end
  end

  // m_ready reaches rd_en combinationally so a full buffer being drained can refill every cycle.
  assign rd_en = rst_n & ~bus.fifo_empty & (occ_after < DepthOcc);

  always_comb begin
    buf_mem_d    = buf_mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    buf_count_d  = buf_count_q;
    rd_pending_d = rd_en;
    xfer_count_d = xfer_count_q;

    if (rd_pending_q) begin
      buf_mem_d[wr_ptr_q] = bus.fifo_data_out;
      wr_ptr_d            = wr_ptr_q + 1'b1;
    end

    if (pop) begin
      rd_ptr_d     = rd_ptr_q + 1'b1;
      xfer_count_d = xfer_count_q + 1'b1;
    end

    unique case ({rd_pending_q, pop})
      2'b10:   buf_count_d = buf_count_q + 1'b1;
      2'b01:   buf_count_d = buf_count_q - 1'b1;
      default: buf_count_d = buf_count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      buf_count_q  <= '0;
      rd_pending_q <= 1'b0;
      xfer_count_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      buf_count_q  <= buf_count_d;
      rd_pending_q <= rd_pending_d;
      xfer_count_q <= xfer_count_d;
    end
  end

  // Data storage carries no reset; buf_count gates visibility of stale entries.
  always_ff @(posedge clk) begin
    buf_mem_q <= buf_mem_d;
  end

  assign bus.fifo_rd_en = rd_en;
  assign bus.m_valid    = m_valid;
  assign bus.m_data     = buf_mem_q[rd_ptr_q];
  assign bus.buf_count  = buf_count_q;
  assign bus.xfer_count = xfer_count_q;

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Bench for fifo_rd_stream_adapter: a queue-based FIFO model feeds the DUT, a per-cycle
// scoreboard checks stream order/occupancy, and directed tests pin literal expectations.
module tb_fifo_rd_stream_adapter;

  localparam int unsigned FW = 16;
  localparam int unsigned BD = 2;
  localparam int unsigned CW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic m_ready = 1'b0;
  logic hold_nonempty = 1'b0;

  logic          fifo_empty = 1'b1;
  logic [FW-1:0] fifo_dout = '0;
  logic          underflow = 1'b0;
  logic          dut_empty;

  logic          rd_en_w, m_valid_w;
  logic [FW-1:0] m_data_w;
  logic [$clog2(BD):0] buf_count_w;
  logic [CW-1:0] xfer_count_w;

  logic [FW-1:0] stim_q [$];
  logic [FW-1:0] fifo_q [$];
  logic [FW-1:0] written [$];
  int            wr_idx = 0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fifo_rd_stream_adapter_if #(.FIFO_WIDTH(FW), .BUF_DEPTH(BD), .CNT_WIDTH(CW)) bus ();

  assign dut_empty         = fifo_empty & ~hold_nonempty;
  assign bus.fifo_empty    = dut_empty;
  assign bus.fifo_data_out = fifo_dout;
  assign bus.m_ready       = m_ready;
  assign rd_en_w           = bus.fifo_rd_en;
  assign m_valid_w         = bus.m_valid;
  assign m_data_w          = bus.m_data;
  assign buf_count_w       = bus.buf_count;
  assign xfer_count_w      = bus.xfer_count;

  fifo_rd_stream_adapter #(.FIFO_WIDTH(FW), .BUF_DEPTH(BD), .CNT_WIDTH(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // FIFO model: registered read data, empty updates after the clock edge, sticky underflow.
  always @(posedge clk) begin
    if (!rst_n) begin
      fifo_q.delete();
      written.delete();
      wr_idx = stim_q.size();
      fifo_empty <= 1'b1;
      fifo_dout  <= '0;
    end else begin
      if (rd_en_w) begin
        if (fifo_q.size() == 0) underflow <= 1'b1;
        else fifo_dout <= fifo_q.pop_front();
      end
      while (wr_idx < stim_q.size()) begin
        fifo_q.push_back(stim_q[wr_idx]);
        written.push_back(stim_q[wr_idx]);
        wr_idx++;
      end
      fifo_empty <= (fifo_q.size() == 0);
    end
  end

  // Scoreboard: words taken from the FIFO vs words delivered, by count.
  int   m_taken = 0;
  int   m_deliv = 0;
  int   m_last_rd = 0;
  int   m_buf;
  logic exp_valid, exp_pop, exp_rd, stall_prev = 1'b0;
  logic [FW-1:0] prev_data;

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rd_en_in_reset", {31'd0, rd_en_w}, 32'd0);
      m_taken = 0; m_deliv = 0; m_last_rd = 0; stall_prev = 1'b0;
    end else begin
      m_buf     = m_taken - m_last_rd - m_deliv;
      exp_valid = (m_buf != 0);
      check("m_valid", {31'd0, m_valid_w}, {31'd0, exp_valid});
      check("buf_count", 32'(buf_count_w), 32'(m_buf));
      check("xfer_count", 32'(xfer_count_w), 32'(m_deliv % (1 << CW)));
      exp_pop = exp_valid && m_ready;
      exp_rd  = !dut_empty && ((m_taken - m_deliv - int'(exp_pop)) < int'(BD));
      check("fifo_rd_en", {31'd0, rd_en_w}, {31'd0, exp_rd});
      if (stall_prev) check("m_data_hold", 32'(m_data_w), 32'(prev_data));
      if (exp_pop) begin
        if (m_deliv < written.size()) check("m_data_order", 32'(m_data_w), 32'(written[m_deliv]));
        else check("m_data_extra", 32'(m_data_w), 32'hFFFF_FFFF);
      end
      stall_prev = exp_valid && !m_ready;
      prev_data  = m_data_w;
      m_taken    = m_taken + int'(exp_rd);
      m_last_rd  = int'(exp_rd);
      m_deliv    = m_deliv + int'(exp_pop);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int rd_cnt, v_cnt, first_rd, last_rd, first_v, last_v, n, guard;
    logic [FW-1:0] got [$];

    // 1: reset hold with a non-empty FIFO
    m_ready = 1'b1;
    hold_nonempty = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t1_rd_en", {31'd0, rd_en_w}, 32'd0);
      check("t1_m_valid", {31'd0, m_valid_w}, 32'd0);
      check("t1_buf_count", 32'(buf_count_w), 32'd0);
      check("t1_xfer_count", 32'(xfer_count_w), 32'd0);
    end
    step();
    hold_nonempty = 1'b0;
    step();
    rst_n = 1'b1;
    step();

    // 2: streaming 8 words
    for (int i = 1; i <= 8; i++) stim_q.push_back(FW'(i));
    rd_cnt = 0; v_cnt = 0; first_rd = -1; last_rd = -1; first_v = -1; last_v = -1;
    got.delete();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rd_en_w) begin
        rd_cnt++; last_rd = i;
        if (first_rd < 0) first_rd = i;
      end
      if (m_valid_w) begin
        v_cnt++; last_v = i; got.push_back(m_data_w);
        if (first_v < 0) first_v = i;
      end
    end
    check("t2_rd_count", 32'(rd_cnt), 32'd8);
    check("t2_rd_contig", 32'(last_rd - first_rd), 32'd7);
    check("t2_valid_count", 32'(v_cnt), 32'd8);
    check("t2_valid_contig", 32'(last_v - first_v), 32'd7);
    check("t2_latency", 32'(first_v - first_rd), 32'd2);
    for (int i = 0; i < got.size(); i++) check("t2_data", 32'(got[i]), 32'(i + 1));
    check("t2_xfer_count", 32'(xfer_count_w), 32'd8);
    check("t2_underflow", {31'd0, underflow}, 32'd0);

    // 3: backpressure
    step();
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) stim_q.push_back(16'hA000 + FW'(i));
    rd_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rd_en_w) rd_cnt++;
    end
    check("t3_rd_count", 32'(rd_cnt), 32'd2);
    check("t3_buf_count", 32'(buf_count_w), 32'd2);
    check("t3_m_data", 32'(m_data_w), 32'hA000);
    step();
    m_ready = 1'b1;
    got.delete();
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (m_valid_w) got.push_back(m_data_w);
    end
    check("t3_delivered", 32'(got.size()), 32'd5);
    for (int i = 0; i < got.size(); i++) check("t3_data", 32'(got[i]), 32'hA000 + 32'(i));

    // 4: single word
    step();
    stim_q.push_back(16'h5A5A);
    rd_cnt = 0; v_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rd_en_w) rd_cnt++;
      if (m_valid_w) begin
        v_cnt++;
        check("t4_data", 32'(m_data_w), 32'h5A5A);
      end
    end
    check("t4_rd_count", 32'(rd_cnt), 32'd1);
    check("t4_valid_count", 32'(v_cnt), 32'd1);
    check("t4_underflow", {31'd0, underflow}, 32'd0);

    // 5: reset with a full buffer drained into a pending read
    step();
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) stim_q.push_back(16'hB000 + FW'(i));
    for (int i = 0; i < 8; i++) step();
    @(negedge clk);
    check("t5_buf_full", 32'(buf_count_w), 32'd2);
    step();
    m_ready = 1'b1;
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("t5_buf_count", 32'(buf_count_w), 32'd0);
    check("t5_m_valid", {31'd0, m_valid_w}, 32'd0);
    check("t5_xfer_count", 32'(xfer_count_w), 32'd0);
    v_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (m_valid_w) v_cnt++;
    end
    check("t5_no_stale", 32'(v_cnt), 32'd0);

    // 6: 17 words with random m_ready, 4-bit counter wraps to 1
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 17; i++) stim_q.push_back(16'h0100 + FW'(i));
    n = 0; guard = 0;
    while (n < 17 && guard < 400) begin
      @(posedge clk);
      #1;
      m_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (m_valid_w && m_ready) begin
        check("t6_data", 32'(m_data_w), 32'h0100 + 32'(n));
        n++;
      end
      guard++;
    end
    check("t6_delivered", 32'(n), 32'd17);
    step();
    m_ready = 1'b0;
    @(negedge clk);
    check("t6_xfer_wrap", 32'(xfer_count_w), 32'd1);
    check("t6_underflow", {31'd0, underflow}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
